// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag index and issue-FSM definitions
package alu_pkg;

  localparam logic [2:0] OP_ADDU = 3'b000;
  localparam logic [2:0] OP_ADDS = 3'b001;
  localparam logic [2:0] OP_SUBU = 3'b010;
  localparam logic [2:0] OP_SUBS = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 1;
  localparam int FLG_ZERO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } issue_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - team ALU: one registered stage from operand sample to result/flags
module alu
  import alu_pkg::*;
#(
  parameter int NUMBITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUMBITS-1:0] a,
  input  logic [NUMBITS-1:0] b,
  input  logic [2:0]         op,
  output logic [NUMBITS-1:0] result,
  output logic               carryout,
  output logic               overflow
);

  localparam int M = NUMBITS - 1;

  logic [NUMBITS-1:0] result_q, result_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic [NUMBITS:0]   sum;
  logic [NUMBITS:0]   diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Subtract reports borrow on the carry flag; shift reports the bit shifted out.
  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    unique case (op)
      OP_ADDU: begin
        result_d = sum[M:0];
        carry_d  = sum[NUMBITS];
      end
      OP_ADDS: begin
        result_d = sum[M:0];
        carry_d  = sum[NUMBITS];
        ovf_d    = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      OP_SUBU: begin
        result_d = diff[M:0];
        carry_d  = diff[NUMBITS];
      end
      OP_SUBS: begin
        result_d = diff[M:0];
        carry_d  = diff[NUMBITS];
        ovf_d    = (a[M] != b[M]) && (diff[M] != a[M]);
      end
      OP_AND: result_d = a & b;
      OP_OR:  result_d = a | b;
      OP_XOR: result_d = a ^ b;
      OP_SHR: begin
        result_d = a >> 1;
        carry_d  = a[0];
      end
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result   = result_q;
  assign carryout = carry_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-outstanding request sequencer around the registered team ALU
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NUMBITS = 16,
  parameter int ALU_LAT = 1,
  parameter int TAGW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [NUMBITS-1:0] req_a,
  input  logic [NUMBITS-1:0] req_b,
  input  logic [2:0]         req_op,
  input  logic [TAGW-1:0]    req_tag,
  output logic [NUMBITS-1:0] alu_a,
  output logic [NUMBITS-1:0] alu_b,
  output logic [2:0]         alu_op,
  input  logic [NUMBITS-1:0] alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [NUMBITS-1:0] rsp_result,
  output logic [2:0]         rsp_flags,
  output logic [TAGW-1:0]    rsp_tag,
  input  logic               clr_sticky,
  output logic [1:0]         sticky_flags,
  output logic               busy
);

  localparam int CNTW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  issue_state_t       state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [NUMBITS-1:0] alu_a_q, alu_a_d;
  logic [NUMBITS-1:0] alu_b_q, alu_b_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic [TAGW-1:0]    tag_q, tag_d;
  logic [NUMBITS-1:0] rsp_result_q, rsp_result_d;
  logic [2:0]         rsp_flags_q, rsp_flags_d;
  logic [TAGW-1:0]    rsp_tag_q, rsp_tag_d;
  logic [1:0]         sticky_q, sticky_d;
  logic               accept;
  logic               capture;

  assign req_ready = reset && ((state_q == ST_IDLE) ||
                               ((state_q == ST_RESP) && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign capture   = (state_q == ST_EXEC) && (cnt_q == CNTW'(ALU_LAT));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    tag_d        = tag_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_tag_d    = rsp_tag_q;

    unique case (state_q)
      ST_IDLE: ;
      ST_EXEC: begin
        cnt_d = cnt_q + CNTW'(1);
        if (capture) begin
          rsp_result_d            = alu_result;
          rsp_flags_d[FLG_CARRY]  = alu_carryout;
          rsp_flags_d[FLG_OVF]    = alu_overflow;
          rsp_flags_d[FLG_ZERO]   = (alu_result == '0);
          rsp_tag_d               = tag_q;
          state_d                 = ST_RESP;
        end
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Accept overrides the RESP->IDLE retire so a back-to-back request goes straight to EXEC.
    if (accept) begin
      alu_a_d  = req_a;
      alu_b_d  = req_b;
      alu_op_d = req_op;
      tag_d    = req_tag;
      cnt_d    = '0;
      state_d  = ST_EXEC;
    end

    sticky_d = (clr_sticky ? 2'b00 : sticky_q) |
               (capture ? {alu_carryout, alu_overflow} : 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      tag_q        <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_tag_q    <= '0;
      sticky_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      tag_q        <= tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_tag_q    <= rsp_tag_d;
      sticky_q     <= sticky_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_result   = rsp_result_q;
  assign rsp_flags    = rsp_flags_q;
  assign rsp_tag      = rsp_tag_q;
  assign sticky_flags = sticky_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed scoreboard bench for alu_issue_ctrl with the team ALU
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [2:0]  req_op;
  logic [3:0]  req_tag;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_carryout;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic [3:0]  rsp_tag;
  logic        clr_sticky;
  logic [1:0]  sticky_flags;
  logic        busy;

  alu_issue_ctrl #(.NUMBITS(16), .ALU_LAT(1), .TAGW(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .clr_sticky(clr_sticky), .sticky_flags(sticky_flags), .busy(busy)
  );

  alu #(.NUMBITS(16)) u_alu (
    .clk(clk), .reset(reset),
    .a(alu_a), .b(alu_b), .op(alu_op),
    .result(alu_result), .carryout(alu_carryout), .overflow(alu_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  flg;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   rsp_cyc[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] tag, input logic [15:0] eres, input logic [2:0] eflg);
    exp_t e;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    e.res = eres;
    e.flg = eflg;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Evaluates handshakes just before the coming posedge, then returns at the following negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (rsp_valid && rsp_ready) begin
      rsp_cyc.push_back(cyc);
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL rsp_unexpected observed tag=%0d expected no response", rsp_tag);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_flags", rsp_flags, e.flg);
        chk("rsp_tag", rsp_tag, e.tag);
      end
    end
    acc = req_valid && req_ready;
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_rsp(input int budget, output int n);
    n = 0;
    while (!rsp_valid && n < budget) begin
      tick();
      n++;
    end
    chk("rsp_valid_timeout", rsp_valid, 1);
  endtask

  task automatic wait_acc(input int budget);
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < budget) begin
      tick();
      n++;
    end
    chk("accept_timeout", acc, 1);
  endtask

  initial begin
    int n;
    reset = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
    rsp_ready = 1'b0; clr_sticky = 1'b0;

    @(negedge clk);
    tick();
    tick();
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_outs", {alu_a, alu_op, rsp_flags, rsp_tag, sticky_flags}, 0);
    chk("rst_rsp_result", rsp_result, 0);
    reset = 1'b1;
    #1;
    chk("post_rst_req_ready", req_ready, 1);

    // ADDU wrap: carry and zero, latency ALU_LAT+1
    rsp_ready = 1'b1;
    issue(OP_ADDU, 16'hFFFF, 16'h0001, 4'd3, 16'h0000, 3'b101);
    wait_acc(4);
    req_valid = 1'b0;
    chk("exec_busy", busy, 1);
    chk("exec_alu_a", alu_a, 16'hFFFF);
    wait_rsp(8, n);
    chk("latency", n, 2);
    chk("sticky_after_add", sticky_flags, 2'b10);
    tick();
    chk("idle_after_rsp", {busy, rsp_valid}, 2'b00);

    // AND under backpressure, then back-to-back retire + accept
    rsp_ready = 1'b0;
    issue(OP_AND, 16'h0F0F, 16'h00FF, 4'd7, 16'h000F, 3'b000);
    wait_acc(4);
    wait_rsp(8, n);
    issue(OP_ADDS, 16'h7FFF, 16'h0001, 4'd8, 16'h8000, 3'b010);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_result", rsp_result, 16'h000F);
      chk("bp_flags", rsp_flags, 3'b000);
      tick();
    end
    chk("bp_alu_a_stable", alu_a, 16'h0F0F);
    rsp_ready = 1'b1;
    tick();
    chk("b2b_accept", acc, 1);
    req_valid = 1'b0;
    chk("b2b_exec", {busy, rsp_valid}, 2'b10);
    chk("b2b_alu_a", alu_a, 16'h7FFF);
    wait_rsp(8, n);
    tick();
    chk("sticky_accum", sticky_flags, 2'b11);

    // Streaming throughput
    rsp_cyc.delete();
    issue(OP_XOR, 16'hAAAA, 16'h5555, 4'd0, 16'hFFFF, 3'b000);
    wait_acc(6);
    issue(OP_OR, 16'h0000, 16'h0000, 4'd1, 16'h0000, 3'b001);
    wait_acc(6);
    issue(OP_SHR, 16'h0002, 16'h0001, 4'd2, 16'h0001, 3'b000);
    wait_acc(6);
    req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("stream_drained", sb.size(), 0);
    chk("stream_rsp_count", rsp_cyc.size(), 3);
    if (rsp_cyc.size() == 3) begin
      chk("stream_gap01", rsp_cyc[1] - rsp_cyc[0], 3);
      chk("stream_gap12", rsp_cyc[2] - rsp_cyc[1], 3);
    end

    // clr_sticky coinciding with a capture keeps only the new flags
    rsp_ready = 1'b0;
    issue(OP_ADDU, 16'hFFFF, 16'h0002, 4'd9, 16'h0001, 3'b100);
    wait_acc(4);
    req_valid = 1'b0;
    tick();
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("clr_on_capture_valid", rsp_valid, 1);
    chk("clr_on_capture_sticky", sticky_flags, 2'b10);
    clr_sticky = 1'b1;
    rsp_ready  = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("clr_alone_sticky", sticky_flags, 2'b00);

    // Reset with tag 5 in flight: dropped, never answered
    req_valid = 1'b1; req_op = OP_ADDU; req_a = 16'h0001; req_b = 16'h0001; req_tag = 4'd5;
    wait_acc(4);
    req_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_req_ready", req_ready, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_idle", {busy, rsp_valid}, 2'b00);
    chk("midrst_req_ready_after", req_ready, 1);
    chk("midrst_regs", {alu_a, rsp_tag, sticky_flags}, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_rsp", rsp_valid, 0);
    end
    chk("sb_empty_end", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
